mdu_ctrl: RTL

//  Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.

---
 rtl/mdu_ctrl_if.sv | 30 +++
 rtl/mdu_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - EX-stage request/response bundle for the multiply/divide unit
// Purpose: groups the MDU request (start/mdu_op/A/B/flush) and status/result
//          (busy/stall/done/hi/lo) signals.
// Ports (via modports):
//   master: drives start, mdu_op, A, B, flush; observes busy, stall, done, hi, lo
//   slave : the MDU side, directions reversed
interface mdu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       mdu_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mdu_op, A, B, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, mdu_op, A, B, flush,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide unit with HI/LO registers
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, computes the result
//          on acceptance and commits it to HI/LO after a fixed busy latency.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 7-10),
//          which accumulate into HI/LO at commit time.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   mdu    slave modport of mdu_ctrl_if:
//          start/mdu_op/A/B/flush in, busy/done/hi/lo registered out,
//          stall combinational out
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_ctrl_if.slave mdu
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic { IDLE, RUN } state_t;
  // How the pending result is applied to {hi,lo} at commit.
  typedef enum logic [1:0] { PM_WRITE, PM_KEEP, PM_ADD, PM_SUB } pend_mode_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  pend_mode_t       pend_mode;

  logic is_mul, is_div, is_md, accept, op_signed;

  always_comb begin
    is_mul = (mdu.mdu_op == OP_MULT) || (mdu.mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (mdu.mdu_op == OP_MADD) || (mdu.mdu_op == OP_MADDU) ||
             (mdu.mdu_op == OP_MSUB) || (mdu.mdu_op == OP_MSUBU);
`endif
    is_div    = (mdu.mdu_op == OP_DIV) || (mdu.mdu_op == OP_DIVU);
    is_md     = is_mul || is_div;
    op_signed = (mdu.mdu_op == OP_MULT) || (mdu.mdu_op == OP_DIV) ||
                (mdu.mdu_op == OP_MADD) || (mdu.mdu_op == OP_MSUB);
    accept    = (state == IDLE) && mdu.start && !mdu.flush && is_md;
  end

  assign mdu.stall = mdu.busy | (mdu.start & ~mdu.flush & is_md);

  // Product: a 2W-bit multiply of sign- or zero-extended operands yields the
  // correct signed or unsigned 2W-bit result modulo 2^(2W).
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  always_comb begin
    a_ext = {{WIDTH{op_signed & mdu.A[WIDTH-1]}}, mdu.A};
    b_ext = {{WIDTH{op_signed & mdu.B[WIDTH-1]}}, mdu.B};
    prod  = a_ext * b_ext;
  end

  // Division on magnitudes, then sign fix-up. This also makes MIN/-1 fall out
  // as quotient MIN, remainder 0 without a special case.
  logic [WIDTH-1:0] dvd, dvs, q_mag, r_mag, quot, rem;
  logic             a_neg, b_neg;
  always_comb begin
    a_neg = op_signed & mdu.A[WIDTH-1];
    b_neg = op_signed & mdu.B[WIDTH-1];
    dvd   = a_neg ? -mdu.A : mdu.A;
    dvs   = b_neg ? -mdu.B : mdu.B;
    // Divide-by-zero result is discarded; substitute 1 to keep the divider defined.
    if (dvs == '0) dvs = {{(WIDTH-1){1'b0}}, 1'b1};
    q_mag = dvd / dvs;
    r_mag = dvd % dvs;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mdu.busy  <= 1'b0;
      mdu.done  <= 1'b0;
      mdu.hi    <= '0;
      mdu.lo    <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_mode <= PM_WRITE;
    end else begin
      case (state)
        IDLE: begin
          mdu.done <= 1'b0;
          if (accept) begin
            state    <= RUN;
            mdu.busy <= 1'b1;
            if (is_div) begin
              cnt      <= CW'(DIV_CYCLES);
              mdu.done <= (DIV_CYCLES == 1);
              pend_hi  <= rem;
              pend_lo  <= quot;
              pend_mode <= (mdu.B == '0) ? PM_KEEP : PM_WRITE;
            end else begin
              cnt      <= CW'(MULT_CYCLES);
              mdu.done <= (MULT_CYCLES == 1);
              {pend_hi, pend_lo} <= prod;
              if ((mdu.mdu_op == OP_MADD) || (mdu.mdu_op == OP_MADDU))
                pend_mode <= PM_ADD;
              else if ((mdu.mdu_op == OP_MSUB) || (mdu.mdu_op == OP_MSUBU))
                pend_mode <= PM_SUB;
              else
                pend_mode <= PM_WRITE;
            end
          end else if (mdu.start && !mdu.flush) begin
            if (mdu.mdu_op == OP_MTHI) mdu.hi <= mdu.A;
            if (mdu.mdu_op == OP_MTLO) mdu.lo <= mdu.A;
          end
        end
        RUN: begin
          // Requests arriving here are ignored; the stall prevents them.
          cnt      <= cnt - 1'b1;
          mdu.done <= (cnt == CW'(2));
          if (cnt == CW'(1)) begin
            state    <= IDLE;
            mdu.busy <= 1'b0;
            case (pend_mode)
              PM_WRITE: {mdu.hi, mdu.lo} <= {pend_hi, pend_lo};
              PM_ADD:   {mdu.hi, mdu.lo} <= {mdu.hi, mdu.lo} + {pend_hi, pend_lo};
              PM_SUB:   {mdu.hi, mdu.lo} <= {mdu.hi, mdu.lo} - {pend_hi, pend_lo};
              default:  ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
